// File: rtl/mt_pc_sched.sv
// Per-thread PC file and round-robin IF scheduler for the fine-grained multithreaded pipeline.
// Latency: if_pc / imem_addr are combinational from registered if_tid and pc[]; selection updates at each edge.
// Backpressure: stall freezes selection and fetch increments; branch redirect and halt/resume still apply.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   stall                      global freeze of scheduler and fetch-driven PC increments
//   thread_en                  per-thread schedule enable mask
//   br_valid/br_tid/br_target  redirect from ID, highest priority PC write (applies under stall)
//   halt_*/resume_*            set/clear a thread's halt flag (halt wins on collision)
//   if_valid/if_tid/if_pc      fetch issued this cycle, its thread and PC
//   imem_addr                  {if_tid, if_pc}
//   pc_all                     all PCs, thread 0 in LSBs
//   halted                     current halt flags
module mt_pc_sched #(
    parameter int                NUM_THREADS = 4,
    parameter int                TID_W       = 2,
    parameter int                PC_W        = 7,
    parameter logic [PC_W-1:0]   RESET_PC    = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        stall,
    input  logic [NUM_THREADS-1:0]      thread_en,
    input  logic                        br_valid,
    input  logic [TID_W-1:0]            br_tid,
    input  logic [PC_W-1:0]             br_target,
    input  logic                        halt_valid,
    input  logic [TID_W-1:0]            halt_tid,
    input  logic                        resume_valid,
    input  logic [TID_W-1:0]            resume_tid,
    output logic                        if_valid,
    output logic [TID_W-1:0]            if_tid,
    output logic [PC_W-1:0]             if_pc,
    output logic [TID_W+PC_W-1:0]       imem_addr,
    output logic [NUM_THREADS*PC_W-1:0] pc_all,
    output logic [NUM_THREADS-1:0]      halted
);

    localparam logic [TID_W-1:0] LAST_TID = TID_W'(NUM_THREADS - 1);

    logic [PC_W-1:0]        pc_q   [NUM_THREADS];
    logic [PC_W-1:0]        pc_nxt [NUM_THREADS];
    logic [NUM_THREADS-1:0] halted_q;
    logic [NUM_THREADS-1:0] halt_vec;
    logic [NUM_THREADS-1:0] resume_vec;
    logic [NUM_THREADS-1:0] halted_nxt;
    logic [NUM_THREADS-1:0] elig;
    logic [TID_W-1:0]       sel_tid;
    logic [TID_W-1:0]       cand;
    logic                   sel_found;

    // Halt and resume decode; halt is OR'd in after the resume mask so it wins a collision.
    always_comb begin
        halt_vec   = '0;
        resume_vec = '0;
        if (halt_valid)   halt_vec[halt_tid]     = 1'b1;
        if (resume_valid) resume_vec[resume_tid] = 1'b1;
        halted_nxt = (halted_q & ~resume_vec) | halt_vec;
        elig       = thread_en & ~halted_nxt;
    end

    // Round-robin search starting one past the current thread; current thread is tried last.
    always_comb begin
        sel_found = 1'b0;
        sel_tid   = if_tid;
        cand      = if_tid;
        for (int k = 1; k <= NUM_THREADS; k++) begin
            cand = TID_W'((int'(if_tid) + k) % NUM_THREADS);
            if (!sel_found && elig[cand]) begin
                sel_found = 1'b1;
                sel_tid   = cand;
            end
        end
    end

    // Redirect beats fetch increment. A thread being halted at this edge does not advance,
    // so it resumes at the instruction it was fetching.
    always_comb begin
        for (int i = 0; i < NUM_THREADS; i++) begin
            pc_nxt[i] = pc_q[i];
            if (br_valid && br_tid == TID_W'(i)) begin
                pc_nxt[i] = br_target;
            end else if (if_valid && !stall && if_tid == TID_W'(i) &&
                         !(halt_valid && halt_tid == TID_W'(i))) begin
                pc_nxt[i] = pc_q[i] + PC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_THREADS; i++) pc_q[i] <= RESET_PC;
            halted_q <= '0;
            if_valid <= 1'b0;
            if_tid   <= LAST_TID;
        end else begin
            for (int i = 0; i < NUM_THREADS; i++) pc_q[i] <= pc_nxt[i];
            halted_q <= halted_nxt;
            if (!stall) begin
                if_valid <= sel_found;
                if (sel_found) if_tid <= sel_tid;
            end
        end
    end

    always_comb begin
        pc_all = '0;
        for (int i = 0; i < NUM_THREADS; i++) pc_all[i*PC_W +: PC_W] = pc_q[i];
    end

    assign if_pc     = pc_q[if_tid];
    assign imem_addr = {if_tid, if_pc};
    assign halted    = halted_q;

endmodule

// File: tb/tb_mt_pc_sched.sv
// Bench for mt_pc_sched: cycle model feeds a scoreboard queue, plus directed constant checks.
// Latency: one expectation pushed per clock edge and popped 1ns after it.
// Backpressure: stall driven by the stimulus sequence.
module tb_mt_pc_sched;

    localparam int NT = 4;
    localparam int TW = 2;
    localparam int PW = 7;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            stall;
    logic [NT-1:0]   thread_en;
    logic            br_valid;
    logic [TW-1:0]   br_tid;
    logic [PW-1:0]   br_target;
    logic            halt_valid;
    logic [TW-1:0]   halt_tid;
    logic            resume_valid;
    logic [TW-1:0]   resume_tid;
    logic            if_valid;
    logic [TW-1:0]   if_tid;
    logic [PW-1:0]   if_pc;
    logic [TW+PW-1:0] imem_addr;
    logic [NT*PW-1:0] pc_all;
    logic [NT-1:0]   halted;

    mt_pc_sched #(.NUM_THREADS(NT), .TID_W(TW), .PC_W(PW), .RESET_PC(7'd0)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .thread_en(thread_en),
        .br_valid(br_valid), .br_tid(br_tid), .br_target(br_target),
        .halt_valid(halt_valid), .halt_tid(halt_tid),
        .resume_valid(resume_valid), .resume_tid(resume_tid),
        .if_valid(if_valid), .if_tid(if_tid), .if_pc(if_pc),
        .imem_addr(imem_addr), .pc_all(pc_all), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          vld;
        logic [TW-1:0] tid;
        logic [NT*PW-1:0] pcs;
        logic [NT-1:0] hlt;
    } exp_t;

    exp_t sbq[$];

    int checks   = 0;
    int failures = 0;

    logic [PW-1:0] m_pc [NT];
    logic          m_vld;
    logic [TW-1:0] m_tid;
    logic [NT-1:0] m_hlt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] pc_of(input int i);
        return pc_all[i*PW +: PW];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NT; i++) m_pc[i] = 7'd0;
        m_vld = 1'b0;
        m_tid = 2'd3;
        m_hlt = '0;
    endtask

    // Model the coming edge from current inputs, queue the expectation, then compare after the edge.
    task automatic tick();
        exp_t          e;
        logic [NT-1:0] hb, rb, hn, el;
        logic [PW-1:0] np [NT];
        logic [TW-1:0] idx;
        bit            found;
        hb = '0;
        rb = '0;
        if (halt_valid)   hb[halt_tid]   = 1'b1;
        if (resume_valid) rb[resume_tid] = 1'b1;
        hn = (m_hlt & ~rb) | hb;
        el = thread_en & ~hn;
        for (int i = 0; i < NT; i++) begin
            np[i] = m_pc[i];
            if (br_valid && int'(br_tid) == i)
                np[i] = br_target;
            else if (m_vld && !stall && int'(m_tid) == i && !(halt_valid && int'(halt_tid) == i))
                np[i] = m_pc[i] + 7'd1;
        end
        if (!stall) begin
            found = 0;
            for (int k = 1; k <= NT; k++) begin
                idx = m_tid + TW'(k);
                if (!found && el[idx]) begin
                    found = 1;
                    m_tid = idx;
                end
            end
            m_vld = found;
        end
        m_hlt = hn;
        for (int i = 0; i < NT; i++) m_pc[i] = np[i];
        e.vld = m_vld;
        e.tid = m_tid;
        e.hlt = m_hlt;
        for (int i = 0; i < NT; i++) e.pcs[i*PW +: PW] = m_pc[i];
        sbq.push_back(e);

        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("sb_vld",   32'(if_valid),  32'(e.vld));
        chk("sb_tid",   32'(if_tid),    32'(e.tid));
        chk("sb_pc",    32'(if_pc),     32'(e.pcs[int'(e.tid)*PW +: PW]));
        chk("sb_addr",  32'(imem_addr), 32'({e.tid, e.pcs[int'(e.tid)*PW +: PW]}));
        chk("sb_pcall", 32'(pc_all),    32'(e.pcs));
        chk("sb_halt",  32'(halted),    32'(e.hlt));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_vld"},   32'(if_valid),  32'd0);
        chk({tag, "_tid"},   32'(if_tid),    32'd3);
        chk({tag, "_pc"},    32'(if_pc),     32'd0);
        chk({tag, "_addr"},  32'(imem_addr), 32'h180);
        chk({tag, "_pcall"}, 32'(pc_all),    32'd0);
        chk({tag, "_halt"},  32'(halted),    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TW-1:0]    t;
        logic [PW-1:0]    p1, p2, p3;
        logic [NT*PW-1:0] pa;
        bit               seen;
        int               exp_seq1 [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
        int               exp_seq3 [4] = '{2, 0, 2, 0};
        int               exp_seq4 [4] = '{0, 1, 3, 0};

        rst_n = 1'b0; stall = 1'b0; thread_en = 4'hF;
        br_valid = 1'b0; br_tid = '0; br_target = '0;
        halt_valid = 1'b0; halt_tid = '0; resume_valid = 1'b0; resume_tid = '0;
        model_reset();
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: free-running round-robin from reset
        for (int n = 0; n < 9; n++) begin
            tick();
            chk("seq1_tid", 32'(if_tid), 32'(exp_seq1[n]));
            if (n == 1) chk("first_t1_addr", 32'(imem_addr), 32'h080);
        end
        chk("all_pc_2", 32'(pc_all), 32'({7'd2, 7'd2, 7'd2, 7'd2}));

        // 2: redirect thread 0 while it is fetching
        br_valid = 1'b1; br_tid = 2'd0; br_target = 7'd5;
        tick();
        br_valid = 1'b0;
        chk("br_pc0", 32'(pc_of(0)), 32'd5);
        chk("br_others", 32'(pc_all[NT*PW-1:PW]), 32'({7'd2, 7'd2, 7'd2}));
        repeat (3) tick();
        chk("br_refetch_tid", 32'(if_tid), 32'd0);
        chk("br_refetch_pc",  32'(if_pc),  32'd5);

        // 3: mask threads 1 and 3
        thread_en = 4'b0101;
        p1 = pc_of(1);
        p3 = pc_of(3);
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("mask_tid", 32'(if_tid), 32'(exp_seq3[n]));
        end
        chk("mask_pc1", 32'(pc_of(1)), 32'(p1));
        chk("mask_pc3", 32'(pc_of(3)), 32'(p3));
        thread_en = 4'hF;

        // 4: halt thread 2 while it is being fetched
        seen = 0;
        for (int n = 0; n < 8 && !seen; n++) begin
            if (if_tid == 2'd2) seen = 1;
            else tick();
        end
        chk("reach_tid2", 32'(seen), 32'd1);
        p2 = pc_of(2);
        halt_valid = 1'b1; halt_tid = 2'd2;
        tick();
        halt_valid = 1'b0;
        chk("halt_pc2", 32'(pc_of(2)), 32'(p2));
        chk("halt_flag", 32'(halted), 32'b0100);
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("halt_seq", 32'(if_tid), 32'(exp_seq4[n]));
        end
        halt_valid = 1'b1; halt_tid = 2'd2; resume_valid = 1'b1; resume_tid = 2'd2;
        tick();
        halt_valid = 1'b0; resume_valid = 1'b0;
        chk("halt_wins", 32'(halted), 32'b0100);
        resume_valid = 1'b1; resume_tid = 2'd2;
        tick();
        resume_valid = 1'b0;
        chk("resume_flag", 32'(halted), 32'b0000);
        seen = 0;
        for (int n = 0; n < 5 && !seen; n++) begin
            tick();
            if (if_tid == 2'd2) seen = 1;
        end
        chk("resume_back", 32'(seen), 32'd1);
        for (int k = 0; k < NT; k++) begin
            halt_valid = 1'b1; halt_tid = TW'(k);
            tick();
        end
        halt_valid = 1'b0;
        chk("allhalt_vld", 32'(if_valid), 32'd0);
        t = if_tid;
        repeat (2) tick();
        chk("allhalt_vld2", 32'(if_valid), 32'd0);
        chk("allhalt_tid",  32'(if_tid),   32'(t));
        for (int k = 0; k < NT; k++) begin
            resume_valid = 1'b1; resume_tid = TW'(k);
            tick();
        end
        resume_valid = 1'b0;
        tick();
        chk("resumed_vld", 32'(if_valid), 32'd1);

        // 5: stall with a redirect underneath, then PC wrap
        stall = 1'b1;
        t  = if_tid;
        pa = pc_all;
        tick();
        br_valid = 1'b1; br_tid = 2'd1; br_target = 7'd9;
        tick();
        br_valid = 1'b0;
        tick();
        chk("stall_tid", 32'(if_tid), 32'(t));
        chk("stall_pc1", 32'(pc_of(1)), 32'd9);
        chk("stall_others", 32'({pc_of(3), pc_of(2), pc_of(0)}), 32'({pa[27:21], pa[20:14], pa[6:0]}));
        stall = 1'b0;
        br_valid = 1'b1; br_tid = 2'd3; br_target = 7'd127;
        tick();
        br_valid = 1'b0;
        seen = 0;
        for (int n = 0; n < 8 && !seen; n++) begin
            if (if_tid == 2'd3 && if_valid) seen = 1;
            else tick();
        end
        chk("reach_tid3", 32'(seen), 32'd1);
        chk("wrap_pre", 32'(if_pc), 32'd127);
        tick();
        chk("wrap_pc3", 32'(pc_of(3)), 32'd0);

        // 6: asynchronous reset between edges
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("arst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("arst_tid0", 32'(if_tid), 32'd0);
        chk("arst_pc0",  32'(pc_all), 32'd0);
        tick();
        chk("arst_tid1", 32'(if_tid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
